// File: rtl/aux_spike_dispatcher_pkg.sv
// Shared types and default widths for the auxiliary spike dispatcher.
// Provides the FSM state encoding and the width used by the saturating counters.
package aux_spike_dispatcher_pkg;

    localparam int DEF_NEURON_WIDTH = 11;
    localparam int DEF_BT_WIDTH     = 36;
    localparam int DEF_COUNT_WIDTH  = 12;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PEEK    = 3'd1,
        ST_POPWAIT = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_DONE    = 3'd4,
        ST_REARM   = 3'd5
    } disp_state_e;

endpackage

// File: rtl/aux_spike_dispatcher_if.sv
// Bundle of the dispatcher's control, queue-head and event-issue signals.
// The slave modport is the dispatcher's view; master is its surroundings.
interface aux_spike_dispatcher_if
    import aux_spike_dispatcher_pkg::*;
#(
    parameter int NEURON_WIDTH = DEF_NEURON_WIDTH,
    parameter int BT_WIDTH     = DEF_BT_WIDTH,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH
);

    logic                    DispatchEnable;
    logic [BT_WIDTH-1:0]     Current_BT;
    logic [NEURON_WIDTH-1:0] InRangeLOWER;
    logic [NEURON_WIDTH-1:0] InRangeUPPER;
    logic [BT_WIDTH-1:0]     AuxBTIn;
    logic [NEURON_WIDTH-1:0] AuxNIDIn;
    logic                    AuxQueueEmpty;
    logic                    AuxDequeueOut;
    logic                    EventValid;
    logic [NEURON_WIDTH-1:0] EventNID;
    logic                    EventReady;
    logic [COUNT_WIDTH-1:0]  DispatchedCount;
    logic [COUNT_WIDTH-1:0]  DroppedCount;
    logic                    DispatchComplete;

    modport master (
        output DispatchEnable, Current_BT, InRangeLOWER, InRangeUPPER,
               AuxBTIn, AuxNIDIn, AuxQueueEmpty, EventReady,
        input  AuxDequeueOut, EventValid, EventNID,
               DispatchedCount, DroppedCount, DispatchComplete
    );

    modport slave (
        input  DispatchEnable, Current_BT, InRangeLOWER, InRangeUPPER,
               AuxBTIn, AuxNIDIn, AuxQueueEmpty, EventReady,
        output AuxDequeueOut, EventValid, EventNID,
               DispatchedCount, DroppedCount, DispatchComplete
    );

endinterface

// File: rtl/aux_spike_dispatcher_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Reset takes priority over clear, clear over increment.
module sat_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/aux_spike_dispatcher.sv
// Drains queued spike events stamped with the current timestep, filters them by
// neuron range and issues accepted ones downstream one at a time.
module aux_spike_dispatcher
    import aux_spike_dispatcher_pkg::*;
#(
    parameter int NEURON_WIDTH = DEF_NEURON_WIDTH,
    parameter int BT_WIDTH     = DEF_BT_WIDTH,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH
) (
    input  logic                   Clock,
    input  logic                   Reset,
    aux_spike_dispatcher_if.slave  bus
);

    disp_state_e             state_q, state_d;
    logic                    event_valid_q, event_valid_d;
    logic [NEURON_WIDTH-1:0] event_nid_q, event_nid_d;
    logic                    complete_q, complete_d;

    logic [BT_WIDTH-1:0]     head_bt;
    logic [BT_WIDTH-1:0]     cur_bt;
    logic [NEURON_WIDTH-1:0] head_nid;
    logic                    head_in_range;
    logic                    pop;
    logic                    drop_inc;
    logic                    disp_inc;
    logic                    cnt_clr;

    assign head_bt       = bus.AuxBTIn;
    assign cur_bt        = bus.Current_BT;
    assign head_nid      = bus.AuxNIDIn;
    assign head_in_range = (head_nid >= bus.InRangeLOWER) && (head_nid <= bus.InRangeUPPER);

    always_comb begin
        state_d       = state_q;
        event_valid_d = 1'b0;
        event_nid_d   = event_nid_q;
        complete_d    = 1'b0;
        pop           = 1'b0;
        drop_inc      = 1'b0;
        cnt_clr       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.DispatchEnable) begin
                    cnt_clr = 1'b1;
                    state_d = ST_PEEK;
                end
            end
            ST_PEEK: begin
                // Future-stamped heads stay queued for a later timestep.
                if (bus.AuxQueueEmpty || (head_bt > cur_bt)) begin
                    complete_d = 1'b1;
                    state_d    = ST_DONE;
                end else if (head_bt < cur_bt) begin
                    pop      = 1'b1;
                    drop_inc = 1'b1;
                    state_d  = ST_POPWAIT;
                end else begin
                    pop         = 1'b1;
                    event_nid_d = head_nid;
                    if (head_in_range) begin
                        event_valid_d = 1'b1;
                        state_d       = ST_ISSUE;
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = ST_POPWAIT;
                    end
                end
            end
            ST_POPWAIT: state_d = ST_PEEK;
            ST_ISSUE: begin
                if (event_valid_q && bus.EventReady) begin
                    state_d = ST_PEEK;
                end else begin
                    event_valid_d = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_REARM;
            ST_REARM: begin
                if (!bus.DispatchEnable) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            event_valid_q <= 1'b0;
            event_nid_q   <= '0;
            complete_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            event_valid_q <= event_valid_d;
            event_nid_q   <= event_nid_d;
            complete_q    <= complete_d;
        end
    end

    // Pop is the only combinational output; it must never fire while in reset.
    assign bus.AuxDequeueOut    = pop && !Reset;
    assign bus.EventValid       = event_valid_q;
    assign bus.EventNID         = event_nid_q;
    assign bus.DispatchComplete = complete_q;

    assign disp_inc = (state_q == ST_ISSUE) && event_valid_q && bus.EventReady;

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_disp_cnt (
        .clk   (Clock),
        .rst   (Reset),
        .clr   (cnt_clr),
        .inc   (disp_inc),
        .count (bus.DispatchedCount)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_drop_cnt (
        .clk   (Clock),
        .rst   (Reset),
        .clr   (cnt_clr),
        .inc   (drop_inc),
        .count (bus.DroppedCount)
    );

endmodule

// File: doc/aux_spike_dispatcher.md
Name: aux_spike_dispatcher

Overview:
- Consumer end of the auxiliary spike queue.
- Once per biological timestep, drains queued (BT, NID) spike events whose timestamp equals Current_BT.
- Filters each event against this core's input neuron range and issues accepted events one at a time to the synaptic/neuron update stage over a valid/ready handshake.
- Leaves future-timestamped events in the queue. Pops and counts stale (past) events.

Parameters:
- NEURON_WIDTH, 11, neuron ID width.
- BT_WIDTH, 36, biological-time width.
- COUNT_WIDTH, 12, width of per-timestep statistics counters.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- DispatchEnable  in  1  level; start dispatch for current timestep.
- Current_BT  in  BT_WIDTH  current biological time.
- InRangeLOWER  in  NEURON_WIDTH  lowest NID accepted by this core (inclusive).
- InRangeUPPER  in  NEURON_WIDTH  highest NID accepted by this core (inclusive).
- AuxBTIn  in  BT_WIDTH  queue head timestamp (first-word-fall-through; valid when !AuxQueueEmpty).
- AuxNIDIn  in  NEURON_WIDTH  queue head NID.
- AuxQueueEmpty  in  1  queue empty flag.
- AuxDequeueOut  out  1  one-cycle pop strobe; head updates on the following cycle.
- EventValid  out  1  event available downstream.
- EventNID  out  NEURON_WIDTH  NID of issued event.
- EventReady  in  1  downstream accepts event.
- DispatchedCount  out  COUNT_WIDTH  events issued this timestep.
- DroppedCount  out  COUNT_WIDTH  stale plus out-of-range events popped this timestep.
- DispatchComplete  out  1  one-cycle pulse at end of dispatch.

Behaviour:
- Reset: state IDLE. All outputs and counters 0, latched NID 0. Reset mid-operation aborts immediately; the queue is not popped during the reset cycle.
- States: IDLE, PEEK, POPWAIT, ISSUE, DONE, REARM.
- IDLE: if DispatchEnable = 1, clear both counters and go to PEEK.
- PEEK (decision is combinational on the head; evaluate in this order):
  - AuxQueueEmpty = 1 -> DONE.
  - AuxBTIn > Current_BT (unsigned, full width) -> DONE. No pop.
  - AuxBTIn < Current_BT -> AuxDequeueOut = 1, DroppedCount += 1, go to POPWAIT.
  - AuxBTIn == Current_BT -> AuxDequeueOut = 1, latch AuxNIDIn.
    - If InRangeLOWER <= NID <= InRangeUPPER (unsigned) -> ISSUE.
    - Otherwise DroppedCount += 1 and go to POPWAIT.
- POPWAIT: one idle cycle so the queue head can update -> PEEK.
- ISSUE: EventValid = 1 and EventNID = latched NID, both held stable until EventReady = 1.
  - On the handshake cycle (EventValid & EventReady): DispatchedCount += 1, then PEEK in the next cycle.
  - EventValid deasserts the cycle after the handshake.
  - The pop already happened at least one cycle earlier, so the head is fresh on return to PEEK.
- DONE: DispatchComplete = 1 for exactly one cycle -> REARM.
- REARM: wait for DispatchEnable = 0, then go to IDLE. This prevents a double dispatch in the same timestep.
- DispatchEnable falling mid-dispatch is ignored; the drain runs to DONE.
- Counters saturate at 2^COUNT_WIDTH - 1 and hold their values until the next start.
- Throughput:
  - Accepted event: 2 cycles minimum (PEEK, ISSUE with EventReady = 1).
  - Dropped event: 2 cycles (PEEK, POPWAIT).
- AuxDequeueOut is asserted only in PEEK and only when AuxQueueEmpty = 0. It never asserts in two consecutive cycles.
- Empty queue at start: DispatchComplete asserts 2 cycles after DispatchEnable is sampled high.

Decomposition:
- Shared package: state encoding for the six states, BT_WIDTH/NEURON_WIDTH defaults, and the saturating-increment width constant.
- One natural sub-module, sat_counter (parameterised width; clear, inc, saturate), instantiated twice for DispatchedCount and DroppedCount.
- FSM, range compare and handshake stay in the top.

Test Plan:
- Empty queue, Current_BT = 5, DispatchEnable high -> no AuxDequeueOut, DispatchComplete pulse 2 cycles later, both counts 0.
- Queue {(5,3),(5,7),(6,1)}, range [0,10], Current_BT = 5, EventReady tied 1:
  - EventNID 3 then 7 issued; 2 pops; (6,1) remains in queue.
  - DispatchedCount = 2, DispatchComplete after the head shows BT 6.
- Queue {(4,2),(5,20),(5,8)}, range [0,15], Current_BT = 5:
  - (4,2) dropped as stale, (5,20) dropped as out of range, NID 8 issued.
  - DroppedCount = 2, DispatchedCount = 1.
- Backpressure: a single event (5,9) with EventReady low for 4 cycles -> EventValid and EventNID = 9 held stable all 4 cycles; one handshake; count = 1.
- Re-arm: DispatchEnable held high across DONE -> no second dispatch. Drop it, raise it again -> counters cleared and a new dispatch runs.
- Reset asserted while in ISSUE -> next cycle EventValid = 0, state IDLE, counters 0, no pop.
